// File: rtl/hazard_control_if.sv
// Pipeline-to-hazard-unit bundle: ID-stage instruction attributes and
// memory/branch status in, stall/freeze controls and status out.
interface hazard_control_if #(
  parameter int REG_ADDRESS_LEN = 4
);
  logic                       en_forwarding;
  logic                       ID_valid;
  logic [REG_ADDRESS_LEN-1:0] ID_src1;
  logic [REG_ADDRESS_LEN-1:0] ID_src2;
  logic                       ID_two_src;
  logic                       ID_wb_en;
  logic                       ID_mem_read;
  logic                       ID_mem_write;
  logic [REG_ADDRESS_LEN-1:0] ID_dst;
  logic                       branch_taken;
  logic                       mem_ready;
  logic                       hazard_stall;
  logic                       freeze_all;
  logic                       mem_timeout;
  logic [15:0]                stall_count;

  // Pipeline side: drives the instruction stream, consumes the controls.
  modport master (
    output en_forwarding, ID_valid, ID_src1, ID_src2, ID_two_src,
           ID_wb_en, ID_mem_read, ID_mem_write, ID_dst,
           branch_taken, mem_ready,
    input  hazard_stall, freeze_all, mem_timeout, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  en_forwarding, ID_valid, ID_src1, ID_src2, ID_two_src,
           ID_wb_en, ID_mem_read, ID_mem_write, ID_dst,
           branch_taken, mem_ready,
    output hazard_stall, freeze_all, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_control.sv
// Hazard detection for a 5-stage pipeline: tracks EXE/MEM destinations,
// raises RAW stalls, freezes on slow memory and flags stuck memory waits.
module hazard_control #(
  parameter int REG_ADDRESS_LEN = 4,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  hazard_control_if.slave   bus
);
  localparam int EXE    = 0;
  localparam int MEM    = 1;
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]                 slot_valid_reg;
  logic [1:0]                 slot_wb_en_reg;
  logic [1:0]                 slot_mem_read_reg;
  logic [1:0]                 slot_mem_write_reg;
  logic [REG_ADDRESS_LEN-1:0] slot_dst_reg [2];

  logic [1:0]        src1_match;
  logic [1:0]        src2_match;
  logic              raw_hazard;
  logic              freeze_all;
  logic              hazard_stall;
  logic              id_accept;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_timeout_reg;
  logic              mem_timeout_next;
  logic [15:0]       stall_count_reg;
  logic [15:0]       stall_count_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign src1_match[gi] = slot_valid_reg[gi] & slot_wb_en_reg[gi]
                            & (slot_dst_reg[gi] == bus.ID_src1);
      assign src2_match[gi] = slot_valid_reg[gi] & slot_wb_en_reg[gi]
                            & (slot_dst_reg[gi] == bus.ID_src2) & bus.ID_two_src;
    end
  endgenerate

  // With forwarding only a load still in EXE cannot be bypassed in time.
  always_comb begin
    raw_hazard = 1'b0;
    if (bus.en_forwarding)
      raw_hazard = (src1_match[EXE] | src2_match[EXE]) & slot_mem_read_reg[EXE];
    else
      raw_hazard = (|src1_match) | (|src2_match);
  end

  assign freeze_all   = slot_valid_reg[MEM]
                      & (slot_mem_read_reg[MEM] | slot_mem_write_reg[MEM])
                      & ~bus.mem_ready;
  assign hazard_stall = bus.ID_valid & raw_hazard & ~bus.branch_taken & ~freeze_all;
  assign id_accept    = bus.ID_valid & ~hazard_stall & ~bus.branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_reg     <= '0;
      slot_wb_en_reg     <= '0;
      slot_mem_read_reg  <= '0;
      slot_mem_write_reg <= '0;
      slot_dst_reg[EXE]  <= '0;
      slot_dst_reg[MEM]  <= '0;
    end else if (!freeze_all) begin
      slot_valid_reg[MEM]     <= slot_valid_reg[EXE];
      slot_wb_en_reg[MEM]     <= slot_wb_en_reg[EXE];
      slot_mem_read_reg[MEM]  <= slot_mem_read_reg[EXE];
      slot_mem_write_reg[MEM] <= slot_mem_write_reg[EXE];
      slot_dst_reg[MEM]       <= slot_dst_reg[EXE];
      // A rejected instruction leaves a fully zeroed bubble behind.
      slot_valid_reg[EXE]     <= id_accept;
      slot_wb_en_reg[EXE]     <= id_accept & bus.ID_wb_en;
      slot_mem_read_reg[EXE]  <= id_accept & bus.ID_mem_read;
      slot_mem_write_reg[EXE] <= id_accept & bus.ID_mem_write;
      slot_dst_reg[EXE]       <= id_accept ? bus.ID_dst : '0;
    end
  end

  always_comb begin
    wait_cnt_next    = '0;
    mem_timeout_next = mem_timeout_reg;
    stall_count_next = stall_count_reg;
    if (freeze_all) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
      if (wait_cnt_next == WAIT_MAX)
        mem_timeout_next = 1'b1;
    end
    if (hazard_stall && stall_count_reg != 16'hFFFF)
      stall_count_next = stall_count_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign bus.hazard_stall = hazard_stall;
  assign bus.freeze_all   = freeze_all;
  assign bus.mem_timeout  = mem_timeout_reg;
  assign bus.stall_count  = stall_count_reg;
endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: load-use, non-forwarding RAW, memory
// freeze, timeout, branch squash and asynchronous reset behaviour.
module tb_hazard_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_stalls = 0;
  int   seen;

  hazard_control_if #(.REG_ADDRESS_LEN(4)) hif ();

  hazard_control #(.REG_ADDRESS_LEN(4), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic mr,
                        input logic mw, input logic [3:0] d);
    hif.ID_valid     = v;
    hif.ID_src1      = s1;
    hif.ID_src2      = s2;
    hif.ID_two_src   = two;
    hif.ID_wb_en     = wb;
    hif.ID_mem_read  = mr;
    hif.ID_mem_write = mw;
    hif.ID_dst       = d;
    $display("t=%0t id v=%0b src1=%0d src2=%0d two=%0b wb=%0b mr=%0b mw=%0b dst=%0d fwd=%0b rdy=%0b br=%0b",
             $time, v, s1, s2, two, wb, mr, mw, d, hif.en_forwarding, hif.mem_ready, hif.branch_taken);
  endtask

  task automatic flush();
    hif.branch_taken = 1'b0;
    hif.mem_ready    = 1'b1;
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hif.en_forwarding = 1'b0;
    hif.branch_taken  = 1'b0;
    hif.mem_ready     = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", hif.hazard_stall); end
    total++; if (hif.freeze_all !== 1'b0) begin bad++; $display("FAIL rst_freeze got=%0b want=0", hif.freeze_all); end
    total++; if (hif.mem_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", hif.mem_timeout); end
    total++; if (hif.stall_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", hif.stall_count); end
    rst = 1'b1;
    flush();
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%0b want=0", hif.hazard_stall); end
  endtask

  task automatic test_load_use();
    hif.en_forwarding = 1'b1;
    set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);   // LDR r3
    #1;
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_ldr_stall got=%0b want=0", hif.hazard_stall); end
    tick();
    set_id(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);   // ADD r4 = r3 + r5
    #1;
    total++; if (hif.hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", hif.hazard_stall); end
    exp_stalls++;
    tick();
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_proceed got=%0b want=0", hif.hazard_stall); end
    total++; if (hif.stall_count !== 16'(exp_stalls)) begin bad++; $display("FAIL lu_count got=%0d want=%0d", hif.stall_count, exp_stalls); end
    tick();
    flush();
  endtask

  task automatic test_no_forward();
    hif.en_forwarding = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);   // ADD r2
    tick();
    set_id(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6);   // SUB uses r2 as src2
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (hif.hazard_stall === 1'b1) seen++;
      tick();
    end
    exp_stalls += 2;
    total++; if (seen != 2) begin bad++; $display("FAIL nf_two_src_cycles got=%0d want=2", seen); end
    flush();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    set_id(1'b1, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);   // src2 not actually read
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (hif.hazard_stall === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL nf_one_src_cycles got=%0d want=0", seen); end
    flush();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);   // store: no writeback
    tick();
    set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    #1;
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL nf_no_wb got=%0b want=0", hif.hazard_stall); end
    total++; if (hif.stall_count !== 16'(exp_stalls)) begin bad++; $display("FAIL nf_count got=%0d want=%0d", hif.stall_count, exp_stalls); end
    flush();
  endtask

  task automatic test_freeze();
    hif.en_forwarding = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6);   // LDR r6
    tick();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    hif.mem_ready = 1'b0;
    set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);   // consumer of r6
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (hif.freeze_all === 1'b1) seen++;
      total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL frz_stall_masked cyc=%0d got=%0b want=0", i, hif.hazard_stall); end
      tick();
    end
    total++; if (seen != 4) begin bad++; $display("FAIL frz_cycles got=%0d want=4", seen); end
    hif.mem_ready = 1'b1;
    #1;
    total++; if (hif.freeze_all !== 1'b0) begin bad++; $display("FAIL frz_release got=%0b want=0", hif.freeze_all); end
    // Load must still sit in MEM after the freeze, so the consumer stalls now.
    total++; if (hif.hazard_stall !== 1'b1) begin bad++; $display("FAIL frz_held_slot got=%0b want=1", hif.hazard_stall); end
    total++; if (hif.mem_timeout !== 1'b0) begin bad++; $display("FAIL frz_timeout got=%0b want=0", hif.mem_timeout); end
    exp_stalls++;
    tick();
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL frz_drain got=%0b want=0", hif.hazard_stall); end
    flush();
  endtask

  task automatic test_branch();
    hif.en_forwarding = 1'b1;
    set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);   // LDR r3
    tick();
    hif.branch_taken = 1'b1;
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8);   // LDR r8 <- [r3], squashed
    #1;
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL br_stall got=%0b want=0", hif.hazard_stall); end
    tick();
    hif.branch_taken = 1'b0;
    set_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9);   // would load-use r8 if not bubbled
    #1;
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL br_bubble got=%0b want=0", hif.hazard_stall); end
    total++; if (hif.stall_count !== 16'(exp_stalls)) begin bad++; $display("FAIL br_count got=%0d want=%0d", hif.stall_count, exp_stalls); end
    flush();
  endtask

  task automatic test_timeout();
    hif.en_forwarding = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);   // LDR r9
    tick();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    hif.mem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      total++; if (hif.freeze_all !== 1'b1) begin bad++; $display("FAIL to_freeze k=%0d got=%0b want=1", k, hif.freeze_all); end
      total++; if (hif.mem_timeout !== (k >= 15)) begin bad++; $display("FAIL to_flag k=%0d got=%0b want=%0b", k, hif.mem_timeout, (k >= 15)); end
      tick();
    end
    hif.mem_ready = 1'b1;
    tick();
    total++; if (hif.mem_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b want=1", hif.mem_timeout); end
    total++; if (hif.freeze_all !== 1'b0) begin bad++; $display("FAIL to_release got=%0b want=0", hif.freeze_all); end
    flush();
  endtask

  task automatic test_reset_mid_freeze();
    hif.en_forwarding = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);   // LDR r9
    tick();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    hif.mem_ready = 1'b0;
    #1;
    total++; if (hif.freeze_all !== 1'b1) begin bad++; $display("FAIL mr_frz_before got=%0b want=1", hif.freeze_all); end
    rst = 1'b0;
    #1;
    exp_stalls = 0;
    total++; if (hif.freeze_all !== 1'b0) begin bad++; $display("FAIL mr_frz got=%0b want=0", hif.freeze_all); end
    total++; if (hif.mem_timeout !== 1'b0) begin bad++; $display("FAIL mr_timeout got=%0b want=0", hif.mem_timeout); end
    total++; if (hif.stall_count !== 16'd0) begin bad++; $display("FAIL mr_count got=%0d want=0", hif.stall_count); end
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL mr_stall got=%0b want=0", hif.hazard_stall); end
    tick();
    rst = 1'b1;
    set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10);  // reads r9 of the flushed load
    #1;
    total++; if (hif.hazard_stall !== 1'b0) begin bad++; $display("FAIL mr_first_instr got=%0b want=0", hif.hazard_stall); end
    tick();
    total++; if (hif.stall_count !== 16'd0) begin bad++; $display("FAIL mr_count_after got=%0d want=0", hif.stall_count); end
  endtask

  initial begin
    hif.en_forwarding = 1'b0;
    hif.branch_taken  = 1'b0;
    hif.mem_ready     = 1'b1;
    hif.ID_valid      = 1'b0;
    hif.ID_src1       = '0;
    hif.ID_src2       = '0;
    hif.ID_two_src    = 1'b0;
    hif.ID_wb_en      = 1'b0;
    hif.ID_mem_read   = 1'b0;
    hif.ID_mem_write  = 1'b0;
    hif.ID_dst        = '0;
    test_reset();
    test_load_use();
    test_no_forward();
    test_freeze();
    test_branch();
    test_timeout();
    test_reset_mid_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have parameter REG_ADDRESS_LEN, default 4, meaning register address width.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning consecutive memory-wait cycles before timeout is flagged.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en_forwarding  input  1  forwarding unit enabled.
REQ-006 The block SHALL have port ID_valid  input  1  valid instruction in ID.
REQ-007 The block SHALL have ports ID_src1, ID_src2  input  REG_ADDRESS_LEN  ID source registers.
REQ-008 The block SHALL have port ID_two_src  input  1  ID_src2 is actually read.
REQ-009 The block SHALL have ports ID_wb_en, ID_mem_read, ID_mem_write  input  1 each  ID instruction attributes.
REQ-010 The block SHALL have port ID_dst  input  REG_ADDRESS_LEN  ID destination register.
REQ-011 The block SHALL have port branch_taken  input  1  taken branch resolved in EXE.
REQ-012 The block SHALL have port mem_ready  input  1  data memory completes the access this cycle.
REQ-013 The block SHALL have port hazard_stall  output  1  freeze PC and IF/ID, insert bubble into ID/EX.
REQ-014 The block SHALL have port freeze_all  output  1  hold every pipeline register.
REQ-015 The block SHALL have port mem_timeout  output  1  sticky memory-wait timeout flag.
REQ-016 The block SHALL have port stall_count  output  16  saturating count of hazard_stall cycles.

Function
REQ-017 The block SHALL keep a two-entry scoreboard, EXE slot and MEM slot, each holding {valid, dst, wb_en, mem_read, mem_write}.
REQ-018 Match on srcN SHALL be: slot valid, slot wb_en, slot dst == ID_srcN; the src2 match SHALL also require ID_two_src.
REQ-019 With en_forwarding=1, raw hazard SHALL be EXE-slot match with EXE mem_read=1 (load-use only).
REQ-020 With en_forwarding=0, raw hazard SHALL be any match in the EXE or MEM slot; WB-stage writes SHALL NOT cause a hazard.
REQ-021 freeze_all SHALL be combinational: MEM valid and (mem_read or mem_write) and mem_ready=0.
REQ-022 hazard_stall SHALL be combinational: ID_valid and raw hazard and not branch_taken and not freeze_all.
REQ-023 Priority SHALL be freeze_all > branch_taken > hazard_stall.
REQ-024 On a clock edge with freeze_all=1, both scoreboard slots SHALL hold.
REQ-025 On a clock edge with freeze_all=0, MEM slot SHALL take the EXE slot.
REQ-026 On that same edge, EXE slot SHALL take the ID fields when ID_valid=1, hazard_stall=0 and branch_taken=0, else become a bubble (valid=0, all attributes 0).
REQ-027 A wait counter SHALL increment each cycle freeze_all=1, clear to 0 on any cycle freeze_all=0, and saturate at MEM_TIMEOUT.
REQ-028 mem_timeout SHALL set on the edge where the wait counter reaches MEM_TIMEOUT and remain set until reset.
REQ-029 stall_count SHALL increment on each edge with hazard_stall=1 and saturate at 16'hFFFF.
REQ-030 After a one-cycle load-use stall, the load SHALL move to MEM and the dependent instruction SHALL proceed with hazard_stall=0 (forwarding enabled).

Reset
REQ-031 On rst=0, asynchronously: both slots invalid, wait counter 0, mem_timeout 0, stall_count 0.
REQ-032 During and directly after reset, hazard_stall=0 and freeze_all=0.
REQ-033 Reset asserted mid-freeze SHALL drop freeze_all immediately, since MEM slot becomes invalid.

Verification
REQ-034 en_forwarding=1, LDR r3 then ADD using r3 as src1 -> hazard_stall=1 for exactly 1 cycle, stall_count=1.
REQ-035 en_forwarding=0, ADD r2 then SUB using r2 as src2 with ID_two_src=1 -> hazard_stall=1 for 2 cycles; with ID_two_src=0 -> 0 cycles.
REQ-036 Load in MEM, mem_ready low 4 cycles -> freeze_all=1 for 4 cycles, scoreboard unchanged, mem_timeout=0.
REQ-037 mem_ready held low 20 cycles with MEM_TIMEOUT=15 -> mem_timeout=1 from cycle 15, stays 1 after mem_ready=1.
REQ-038 Load-use hazard present while branch_taken=1 -> hazard_stall=0, EXE slot bubbled, stall_count unchanged.
REQ-039 rst pulsed low during freeze -> all outputs 0 immediately; first post-reset instruction not stalled.
